seg7_scan_ctrl: RTL and testbench

Time-multiplexing controller for the board's 4-digit common-anode 7-segment display (SEG/AN/DP pins). It holds a 16-bit hex value, four decimal-point bits and four digit-enable bits. It scans one digit at a time with a blanking guard between digits to suppress ghosting. New values are applied only at frame boundaries so the display never shows a torn value. It sits in the top level between the CPU/GPIO logic and the display pins.

---
 rtl/seg7_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Each digit slot starts with a blanking guard, and new
// values are double-buffered so they only take effect at frame boundaries.
module seg7_scan_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC  = 64
) (
  input  logic        CLK_100MHz,
  input  logic        n_rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  dig_en_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_tick,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP
);

  // Cycles per digit slot; a frame is four slots.
  localparam int SLOT = CLK_HZ / REFRESH_HZ;
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Scan position and FSM state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_e        state_q;

  // Double buffer: pending (written by load) and active (what is shown)
  logic [15:0] pend_data_q;
  logic [3:0]  pend_dp_q;
  logic [3:0]  pend_en_q;
  logic        pending_q;
  logic [15:0] act_data_q;
  logic [3:0]  act_dp_q;
  logic [3:0]  act_en_q;

  // Registered pin drivers
  logic [6:0] seg_q;
  logic [3:0] an_q;
  logic       dp_q;
  logic       frame_tick_q;

  // Combinational helpers
  logic       slot_wrap;
  logic       boundary;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       show_lit;

  assign slot_wrap = (cnt_q == SLOT_LAST);
  assign boundary  = slot_wrap && (idx_q == 2'd3);
  assign show_lit  = (state_q == ST_SHOW) && act_en_q[idx_q];

  // Next slot position: count within the slot, step the digit on wrap
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Hex to active-low {g,f,e,d,c,b,a} for the digit currently being scanned
  always_comb begin
    nibble = act_data_q[{idx_q, 2'b00} +: 4];
    unique case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  // Scan FSM with registered outputs; pins follow (idx, cnt) by one cycle
  always_ff @(posedge CLK_100MHz or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      seg_q        <= 7'h7F;
      an_q         <= 4'hF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= boundary;
      if (slot_wrap) begin
        state_q <= ST_BLANK;
      end else if (cnt_q == BLANK_LAST) begin
        state_q <= ST_SHOW;
      end
      // Only one anode can ever be driven: the one selected by idx
      if (show_lit) begin
        an_q  <= ~(4'b0001 << idx_q);
        seg_q <= seg_dec;
        dp_q  <= ~act_dp_q[idx_q];
      end else begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end
    end
  end

  // Double buffer: last load wins; active copy swaps only at the frame boundary
  always_ff @(posedge CLK_100MHz or negedge n_rst) begin
    if (!n_rst) begin
      pend_data_q <= 16'h0000;
      pend_dp_q   <= 4'h0;
      pend_en_q   <= 4'h0;
      pending_q   <= 1'b0;
      act_data_q  <= 16'h0000;
      act_dp_q    <= 4'h0;
      act_en_q    <= 4'h0;
    end else begin
      // The swap reads the old pending copy, so a load on the boundary
      // cycle lands in pending for the following frame.
      if (boundary && pending_q) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
        act_en_q   <= pend_en_q;
      end
      if (load) begin
        pend_data_q <= data_in;
        pend_dp_q   <= dp_in;
        pend_en_q   <= dig_en_in;
        pending_q   <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign SEG        = seg_q;
  assign AN         = an_q;
  assign DP         = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SLOT=10, BLANK_CYC=2 (frame = 40).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        n_rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en_in;
  logic        load;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  int n_vec;
  int n_err;

  seg7_scan_ctrl #(
    .CLK_HZ    (1000),
    .REFRESH_HZ(100),
    .BLANK_CYC (2)
  ) dut (
    .CLK_100MHz(clk),
    .n_rst     (n_rst),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .dig_en_in (dig_en_in),
    .load      (load),
    .pending   (pending),
    .frame_tick(frame_tick),
    .SEG       (SEG),
    .AN        (AN),
    .DP        (DP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Segment codes for hex digits, active low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Display dark for ncyc cycles from reset release; frame_tick every 40
  task automatic check_dark(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      check($sformatf("dark k=%0d", k), {20'h0, AN, SEG, DP}, {20'h0, 4'hF, 7'h7F, 1'b1});
      check($sformatf("dark_pend k=%0d", k), {31'h0, pending}, 32'h0);
      check($sformatf("dark_tick k=%0d", k), {31'h0, frame_tick}, {31'h0, (k % 40) == 0});
    end
  endtask

  // Advance to the next frame_tick, bounded
  task automatic wait_ft();
    int found;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (frame_tick === 1'b1) found = 1;
    end
    check("ft_timeout", found, 1);
  endtask

  // Called on a frame_tick cycle. Checks the 40 cycles of one frame showing
  // (data, dp, en), optionally applying loads at edge la0 / la1 (0 = none).
  task automatic frame_check(
    input logic [15:0] data, input logic [3:0] dp, input logic [3:0] en,
    input logic pend0,
    input int la0, input logic [15:0] d0, input logic [3:0] p0, input logic [3:0] e0,
    input int la1, input logic [15:0] d1, input logic [3:0] p1, input logic [3:0] e1);
    logic       pend_exp;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         pos, di, c;
    pend_exp = pend0;
    for (int j = 1; j <= 40; j++) begin
      load = 1'b0;
      if (j == la0) begin
        load = 1'b1; data_in = d0; dp_in = p0; dig_en_in = e0;
        $display("load data=%h dp=%b en=%b at frame edge %0d", d0, p0, e0, j);
      end else if (j == la1) begin
        load = 1'b1; data_in = d1; dp_in = p1; dig_en_in = e1;
        $display("load data=%h dp=%b en=%b at frame edge %0d", d1, p1, e1, j);
      end
      tick();
      load = 1'b0;
      pos = j - 1;
      di  = pos / 10;
      c   = pos % 10;
      if (c >= 2 && en[di]) begin
        exp_an  = ~(4'b0001 << di);
        exp_seg = hex_seg(data[4*di +: 4]);
        exp_dp  = ~dp[di];
      end else begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end
      if (j == la0 || j == la1) pend_exp = 1'b1;
      else if (j == 40) pend_exp = 1'b0;
      check($sformatf("scan %h j=%0d", data, j), {20'h0, AN, SEG, DP}, {20'h0, exp_an, exp_seg, exp_dp});
      check($sformatf("pend %h j=%0d", data, j), {31'h0, pending}, {31'h0, pend_exp});
      check($sformatf("tick %h j=%0d", data, j), {31'h0, frame_tick}, {31'h0, j == 40});
    end
    $display("frame data=%h dp=%b en=%b checked", data, dp, en);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_rst = 1'b0;
    load = 1'b0;
    data_in = 16'h0;
    dp_in = 4'h0;
    dig_en_in = 4'h0;
    tick();
    tick();
    check("rst_out", {20'h0, AN, SEG, DP}, {20'h0, 4'hF, 7'h7F, 1'b1});
    check("rst_tick", {31'h0, frame_tick}, 32'h0);
    check("rst_pend", {31'h0, pending}, 32'h0);
    n_rst = 1'b1;
    check_dark(100);

    // First load, mid-frame, shown from the next frame on
    load = 1'b1; data_in = 16'h1234; dp_in = 4'b0001; dig_en_in = 4'hF;
    $display("load data=1234 dp=0001 en=f");
    tick();
    load = 1'b0;
    check("pend_after_load", {31'h0, pending}, 32'h1);
    wait_ft();
    check("pend_drop_ft", {31'h0, pending}, 32'h0);

    // 1234 frame, ABCD loaded during digit 1
    frame_check(16'h1234, 4'b0001, 4'hF, 1'b0, 15, 16'hABCD, 4'b0000, 4'hF, 0, 16'h0, 4'h0, 4'h0);
    // ABCD frame, 1111 then 8888 loaded: last one wins
    frame_check(16'hABCD, 4'b0000, 4'hF, 1'b0, 5, 16'h1111, 4'b0000, 4'hF, 25, 16'h8888, 4'b0000, 4'hF);
    // 8888 frame, 5678 loaded, then 9ABC on the boundary edge itself
    frame_check(16'h8888, 4'b0000, 4'hF, 1'b0, 10, 16'h5678, 4'b1010, 4'hF, 40, 16'h9ABC, 4'b0001, 4'hF);
    check("pend_kept_boundary", {31'h0, pending}, 32'h1);
    frame_check(16'h5678, 4'b1010, 4'hF, 1'b1, 0, 16'h0, 4'h0, 4'h0, 0, 16'h0, 4'h0, 4'h0);
    // 9ABC frame, partial digit enable loaded
    frame_check(16'h9ABC, 4'b0001, 4'hF, 1'b0, 20, 16'hF0E0, 4'b1111, 4'b0101, 0, 16'h0, 4'h0, 4'h0);
    frame_check(16'hF0E0, 4'b1111, 4'b0101, 1'b0, 0, 16'h0, 4'h0, 4'h0, 0, 16'h0, 4'h0, 4'h0);

    // Into digit 0 SHOW, then asynchronous reset
    for (int j = 0; j < 5; j++) tick();
    check("lit_before_rst", {20'h0, AN, SEG, DP}, {20'h0, 4'hE, 7'h40, 1'b0});
    n_rst = 1'b0;
    #1;
    check("async_rst_out", {20'h0, AN, SEG, DP}, {20'h0, 4'hF, 7'h7F, 1'b1});
    check("async_rst_pend", {31'h0, pending}, 32'h0);
    $display("reset asserted mid-SHOW");
    tick();
    tick();
    n_rst = 1'b1;
    check_dark(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
